// File: rtl/dcache_wb_stage.sv
// Direct-mapped write-back data cache for the MEM stage.
// Misses stall the pipe while a word-serial cs/ack port writes back the victim and fills the line.
`timescale 1ns/1ps

module dcache_byte_lane (
  input  logic       sel,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged_byte
);
  assign merged_byte = sel ? new_byte : old_byte;
endmodule

module dcache_wb_stage #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cpu_en,
  input  logic                read_en,
  input  logic                write_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   store_data,
  output logic [DATA_W-1:0]   load_data,
  output logic                stall,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);
  localparam int NB = DATA_W / 8;
  localparam int BB = $clog2(NB);
  localparam int WO = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW - WO - BB;
  localparam int CW = (WO > 0) ? WO : 1;
  localparam int DW = $clog2(LINES * WORDS_PER_LINE);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [LINES-1:0]      valid_q, dirty_q;
  logic [TW-1:0]         tag_arr  [LINES];
  logic [DATA_W-1:0]     data_arr [LINES*WORDS_PER_LINE];

  logic [IW-1:0]         idx;
  logic [TW-1:0]         req_tag;
  logic [CW-1:0]         off;
  logic [DW-1:0]         word_ptr, fill_ptr;
  logic                  req, hit, last, store_hit;
  logic [DATA_W-1:0]     rd_word;
  logic [NB-1:0][7:0]    merged;
  logic [ADDR_W-1:0]     line_off, wb_addr, fill_addr;
  logic                  unused_addr_bits;

  assign idx     = cpu_addr[BB+WO +: IW];
  assign req_tag = cpu_addr[ADDR_W-1 -: TW];

  generate
    if (WO > 0) begin : g_off
      assign off = cpu_addr[BB +: WO];
    end else begin : g_no_off
      assign off = '0;
    end
  endgenerate

  assign unused_addr_bits = ^cpu_addr;

  assign word_ptr  = (DW'(idx) << WO) | DW'(off);
  assign fill_ptr  = (DW'(idx) << WO) | DW'(cnt_q);
  assign req       = cpu_en & (read_en | write_en);
  assign hit       = valid_q[idx] & (tag_arr[idx] == req_tag);
  assign last      = (cnt_q == CW'(WORDS_PER_LINE - 1));
  assign store_hit = (state_q == IDLE) & req & write_en & hit;
  assign rd_word   = data_arr[word_ptr];
  assign load_data = reset ? '0 : rd_word;

  // Byte-enable merge of store data over the currently stored word
  for (genvar i = 0; i < NB; i++) begin : g_lane
    dcache_byte_lane u_lane (
      .sel         (byte_en[i]),
      .old_byte    (rd_word[8*i +: 8]),
      .new_byte    (store_data[8*i +: 8]),
      .merged_byte (merged[i])
    );
  end

  // Word address = {tag, index, word counter, byte zeros}
  assign line_off  = (ADDR_W'(idx) << (BB + WO)) | (ADDR_W'(cnt_q) << BB);
  assign wb_addr   = (ADDR_W'(tag_arr[idx]) << (ADDR_W - TW)) | line_off;
  assign fill_addr = (ADDR_W'(req_tag) << (ADDR_W - TW)) | line_off;

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: if (req && !hit) begin
        stall   = 1'b1;
        state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
      end
      WB: begin
        stall     = 1'b1;
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_addr;
        mem_wdata = data_arr[fill_ptr];
        if (mem_ack && last) state_d = FILL;
      end
      FILL: begin
        stall    = 1'b1;
        mem_cs   = 1'b1;
        mem_addr = fill_addr;
        if (mem_ack && last) state_d = DONE;
      end
      DONE: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A miss against the cleared arrays must not freeze the pipe while reset is held
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (store_hit) dirty_q[idx] <= 1'b1;
        WB: if (mem_ack) begin
          if (last) begin
            cnt_q        <= '0;
            dirty_q[idx] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FILL: if (mem_ack) begin
          if (last) begin
            cnt_q        <= '0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; valid bits alone qualify their contents
  always_ff @(posedge clock) begin
    if (state_q == FILL && mem_ack) begin
      data_arr[fill_ptr] <= mem_rdata;
      if (last) tag_arr[idx] <= req_tag;
    end else if (store_hit) begin
      data_arr[word_ptr] <= merged;
    end
  end

endmodule

// File: tb/tb_dcache_wb_stage.sv
// Directed bench for dcache_wb_stage: memory model with programmable ack latency,
// scoreboard queue of expected bus operations, stall-length and load-data checks.
`timescale 1ns/1ps

module tb_dcache_wb_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_en = 1'b0, read_en = 1'b0, write_en = 1'b0;
  logic [3:0]  byte_en = '0;
  logic [31:0] cpu_addr = '0, store_data = '0;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic        stall, mem_cs, mem_we, mem_ack;

  int vectors = 0;
  int errors  = 0;
  int ack_wait = 0;
  int wait_cnt = 0;

  logic [31:0] mem [logic [31:0]];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  dcache_wb_stage dut (
    .clock(clock), .reset(reset), .cpu_en(cpu_en), .read_en(read_en),
    .write_en(write_en), .byte_en(byte_en), .cpu_addr(cpu_addr),
    .store_data(store_data), .load_data(load_data), .stall(stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  assign mem_rdata = mem_rd(mem_addr);
  assign mem_ack   = mem_cs && (wait_cnt == ack_wait);

  always @(posedge clock) wait_cnt <= (mem_cs && !mem_ack) ? wait_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  // Bus monitor: every memory cycle must match the head of the expected queue
  always @(negedge clock) begin
    if (mem_cs) begin
      vectors++;
      assert (exp_q.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_mem_op: observed we=%0b addr=%h expected no memory op", mem_we, mem_addr);
        end
      if (exp_q.size() != 0) begin
        chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
        chk("mem_addr", mem_addr, exp_q[0].addr);
        if (mem_ack) begin
          if (exp_q[0].we) begin
            chk("mem_wdata", mem_wdata, exp_q[0].data);
            mem[mem_addr] = mem_wdata;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_line_rd(input logic [31:0] base);
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, base + 32'(4*k), 32'h0});
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int stalls, output logic [31:0] ld);
    @(posedge clock); #1;
    cpu_en = 1'b1; write_en = wr; read_en = !wr;
    cpu_addr = a; store_data = d; byte_en = be;
    stalls = 0;
    forever begin
      @(negedge clock);
      if (!stall) break;
      stalls++;
      if (stalls > 200) begin
        vectors++;
        assert (stalls <= 200)
          else begin errors++; $error("FAIL stall_timeout: observed %0d stall cycles expected completion", stalls); end
        break;
      end
    end
    ld = load_data;
    @(posedge clock); #1;
    cpu_en = 1'b0; write_en = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [31:0] ld, p, modw;

    // Reset state
    @(negedge clock);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_cs", 32'(mem_cs), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    // Cold load, zero-wait ack
    push_line_rd(32'h100);
    access(1'b0, 32'h100, 32'h0, 4'h0, st, ld);
    chk("t1_stall", 32'(st), 32'd6);
    chk("t1_load", ld, pat(32'h100));
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Hit
    access(1'b0, 32'h104, 32'h0, 4'h0, st, ld);
    chk("t2_stall", 32'(st), 32'd0);
    chk("t2_load", ld, pat(32'h104));

    // Partial store hit, then read back
    access(1'b1, 32'h108, 32'hAABBCCDD, 4'b0011, st, ld);
    chk("t3_store_stall", 32'(st), 32'd0);
    p = pat(32'h108);
    modw = {p[31:16], 16'hCCDD};
    access(1'b0, 32'h108, 32'h0, 4'h0, st, ld);
    chk("t3_stall", 32'(st), 32'd0);
    chk("t3_load", ld, modw);

    // Dirty conflict miss: write-back then fill
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4*k);
      exp_q.push_back('{1'b1, a, (k == 2) ? modw : pat(a)});
    end
    push_line_rd(32'h200);
    access(1'b0, 32'h200, 32'h0, 4'h0, st, ld);
    chk("t4_stall", 32'(st), 32'd10);
    chk("t4_load", ld, pat(32'h200));
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Slow memory: 3 wait cycles per word
    ack_wait = 3;
    push_line_rd(32'h340);
    access(1'b0, 32'h340, 32'h0, 4'h0, st, ld);
    chk("t5_stall", 32'(st), 32'd18);
    chk("t5_load", ld, pat(32'h340));
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Refetch of the written-back line returns the merged word
    ack_wait = 1;
    push_line_rd(32'h100);
    access(1'b0, 32'h108, 32'h0, 4'h0, st, ld);
    chk("t5b_stall", 32'(st), 32'd10);
    chk("t5b_load", ld, modw);

    // Reset during the second fill word
    ack_wait = 0;
    exp_q.push_back('{1'b0, 32'h480, 32'h0});
    @(posedge clock); #1;
    cpu_en = 1'b1; read_en = 1'b1; cpu_addr = 32'h480;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1; cpu_en = 1'b0; read_en = 1'b0;
    #1;
    chk("t6_cs_abort", 32'(mem_cs), 32'h0);
    chk("t6_stall_abort", 32'(stall), 32'h0);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    push_line_rd(32'h480);
    access(1'b0, 32'h480, 32'h0, 4'h0, st, ld);
    chk("t6_remiss_stall", 32'(st), 32'd6);
    chk("t6_remiss_load", ld, pat(32'h480));
    push_line_rd(32'h100);
    access(1'b0, 32'h104, 32'h0, 4'h0, st, ld);
    chk("t6_invalid_stall", 32'(st), 32'd6);
    chk("t6_invalid_load", ld, pat(32'h104));
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
